// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared types and constants for the 1-D CNN front end
package cnn1d_pkg;

    localparam int ADC_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } seq_state_t;

    // Population count over up to 16 history bits (voting window maximum).
    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/majority_voter.sv
// rtl/majority_voter.sv - sliding-window majority vote over per-frame conditions
module majority_voter
    import cnn1d_pkg::*;
#(
    parameter int VOTE_DEPTH     = 5,
    parameter int VOTE_THRESHOLD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic bit_in,
    input  logic clear_fill,
    output logic condition_out,
    output logic condition_valid
);

    localparam int FILL_W = $clog2(VOTE_DEPTH + 1);

    logic [VOTE_DEPTH-1:0] history;
    logic [VOTE_DEPTH-1:0] history_next;
    logic [VOTE_DEPTH:0]   history_wide;
    logic [FILL_W-1:0]     fill;
    logic [FILL_W-1:0]     fill_next;
    logic [4:0]            ones_next;

    // Next history / fill values; the vote uses the history including the new result.
    always_comb begin
        history_wide = {history, bit_in};
        history_next = history_wide[VOTE_DEPTH-1:0];
        fill_next    = (fill == FILL_W'(VOTE_DEPTH)) ? fill : fill + 1'b1;
        ones_next    = count_ones(16'(history_next));
    end

    // History shift, saturating fill and registered vote output.
    always_ff @(posedge clk) begin
        if (rst) begin
            history         <= '0;
            fill            <= '0;
            condition_out   <= 1'b0;
            condition_valid <= 1'b0;
        end else begin
            condition_valid <= 1'b0;
            if (shift_en) begin
                history <= history_next;
                fill    <= fill_next;
                if (fill_next >= FILL_W'(VOTE_DEPTH)) begin
                    condition_out   <= (ones_next >= 5'(VOTE_THRESHOLD));
                    condition_valid <= 1'b1;
                end
            end else if (clear_fill) begin
                fill <= '0;
            end
        end
    end

endmodule

// File: rtl/cnn1d_sequencer.sv
// rtl/cnn1d_sequencer.sv - one-frame-per-inference gate between ADC stream and CNN
module cnn1d_sequencer
    import cnn1d_pkg::*;
#(
    parameter int FRAME_SAMPLES  = 102400,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int VOTE_DEPTH     = 5,
    parameter int VOTE_THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic                 adc_valid_in,
    output logic                 adc_ready_in,
    input  logic [ADC_WIDTH-1:0] adc_data_in,
    output logic                 cnn_valid_out,
    input  logic                 cnn_ready_in,
    output logic [ADC_WIDTH-1:0] cnn_data_out,
    input  logic                 res_valid_in,
    input  logic                 res_condition_in,
    output logic                 res_ready_out,
    output logic                 condition_out,
    output logic                 condition_valid,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          frame_count
);

    localparam int SAMPLE_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
    localparam int TIMER_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_t          state;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic [TIMER_W-1:0]  timer;

    logic in_stream;
    logic in_wait;
    logic cnn_hs;
    logic res_hs;
    logic last_sample;
    logic timeout_hit;

    // Handshake gating; STREAM is a zero-latency pass-through, WAIT only accepts results.
    always_comb begin
        in_stream     = (state == STREAM);
        in_wait       = (state == WAIT);
        cnn_valid_out = in_stream & adc_valid_in;
        adc_ready_in  = in_stream & cnn_ready_in;
        cnn_data_out  = in_stream ? adc_data_in : '0;
        res_ready_out = in_wait;
        busy          = (state != IDLE);
        cnn_hs        = in_stream & adc_valid_in & cnn_ready_in;
        res_hs        = in_wait & res_valid_in;
        last_sample   = (sample_cnt == SAMPLE_W'(FRAME_SAMPLES - 1));
        // A result in the terminal cycle takes priority over the watchdog.
        timeout_hit   = in_wait & ~res_valid_in & (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    end

    // Frame sequencing FSM with sample counter, watchdog, error flag and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= STREAM;
                        sample_cnt <= '0;
                    end
                end
                STREAM: begin
                    // enable is not consulted here so a frame is never truncated.
                    if (cnn_hs) begin
                        if (last_sample) begin
                            state      <= WAIT;
                            timer      <= '0;
                            sample_cnt <= '0;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (res_hs) begin
                        frame_count <= frame_count + 16'd1;
                        sample_cnt  <= '0;
                        state       <= enable ? STREAM : IDLE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    majority_voter #(
        .VOTE_DEPTH     (VOTE_DEPTH),
        .VOTE_THRESHOLD (VOTE_THRESHOLD)
    ) u_voter (
        .clk             (clk),
        .rst             (rst),
        .shift_en        (res_hs),
        .bit_in          (res_condition_in),
        .clear_fill      (timeout_hit),
        .condition_out   (condition_out),
        .condition_valid (condition_valid)
    );

endmodule

// File: tb/tb_cnn1d_sequencer.sv
// tb/tb_cnn1d_sequencer.sv - directed self-checking bench for cnn1d_sequencer
module tb_cnn1d_sequencer;
    import cnn1d_pkg::*;

    localparam int FS  = 8;
    localparam int TO  = 20;
    localparam int VD  = 3;
    localparam int VT  = 2;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 clear_err;
    logic                 adc_valid_in;
    logic                 adc_ready_in;
    logic [ADC_WIDTH-1:0] adc_data_in;
    logic                 cnn_valid_out;
    logic                 cnn_ready_in;
    logic [ADC_WIDTH-1:0] cnn_data_out;
    logic                 res_valid_in;
    logic                 res_condition_in;
    logic                 res_ready_out;
    logic                 condition_out;
    logic                 condition_valid;
    logic                 busy;
    logic                 timeout_err;
    logic [15:0]          frame_count;

    cnn1d_sequencer #(
        .FRAME_SAMPLES  (FS),
        .TIMEOUT_CYCLES (TO),
        .VOTE_DEPTH     (VD),
        .VOTE_THRESHOLD (VT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .clear_err        (clear_err),
        .adc_valid_in     (adc_valid_in),
        .adc_ready_in     (adc_ready_in),
        .adc_data_in      (adc_data_in),
        .cnn_valid_out    (cnn_valid_out),
        .cnn_ready_in     (cnn_ready_in),
        .cnn_data_out     (cnn_data_out),
        .res_valid_in     (res_valid_in),
        .res_condition_in (res_condition_in),
        .res_ready_out    (res_ready_out),
        .condition_out    (condition_out),
        .condition_valid  (condition_valid),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .frame_count      (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [ADC_WIDTH-1:0] src_data;
    logic [ADC_WIDTH-1:0] exp_data;

    // delay < 0 means no result is ever presented (watchdog case); pat == 0 means random ready.
    typedef struct {
        logic [7:0]  pat;
        int          delay;
        bit          cond;
        bit          clr;
        bit          exp_valid;
        bit          exp_cond;
        logic [15:0] exp_fc;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream one frame from a counting source; scoreboard checks order at the CNN side.
    task automatic stream_frame(input logic [7:0] pat, input int drop_after,
                                output int got, output bit order_ok);
        int cyc;
        bit drop;
        got      = 0;
        order_ok = 1'b1;
        drop     = 1'b0;
        cyc      = 0;
        while (got < FS && cyc < 200) begin
            tick();
            if (drop) enable = 1'b0;
            adc_valid_in = 1'b1;
            adc_data_in  = src_data;
            if (pat == 8'h00) cnn_ready_in = 1'($urandom_range(0, 1));
            else              cnn_ready_in = pat[cyc[2:0]];
            @(negedge clk);
            if (adc_valid_in && adc_ready_in) src_data = src_data + 1'b1;
            if (cnn_valid_out && cnn_ready_in) begin
                if (cnn_data_out !== exp_data) order_ok = 1'b0;
                exp_data = exp_data + 1'b1;
                got++;
                if (got == drop_after) drop = 1'b1;
            end
            cyc++;
        end
    endtask

    // One WAIT cycle with no result; returns 0 if input was not blocked or results not accepted.
    task automatic wait_idle_cycle(inout bit blocked);
        tick();
        res_valid_in = 1'b0;
        cnn_ready_in = 1'b1;
        adc_valid_in = 1'b1;
        @(negedge clk);
        if (!(res_ready_out && !cnn_valid_out && !adc_ready_in)) blocked = 1'b0;
    endtask

    // Present a result after 'delay' empty WAIT cycles and move to the cycle after the handshake.
    task automatic send_result(input int delay, input bit cond, output bit blocked);
        blocked = 1'b1;
        for (int i = 0; i < delay; i++) wait_idle_cycle(blocked);
        tick();
        res_valid_in     = 1'b1;
        res_condition_in = cond;
        cnn_ready_in     = 1'b0;
        @(negedge clk);
        if (!(res_ready_out && !cnn_valid_out && !adc_ready_in)) blocked = 1'b0;
        tick();
        res_valid_in = 1'b0;
        @(negedge clk);
    endtask

    int got;
    bit ok;
    bit blocked;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        //                  pat    dly cond clr  val cond  fc   err
        vecs[0] = '{8'hFF,   0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[1] = '{8'h00,   2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0};
        vecs[2] = '{8'h3C,   1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0};
        vecs[3] = '{8'h96,   0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0};
        vecs[4] = '{8'hFF,  -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1};
        vecs[5] = '{8'hA5,   0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1};
        vecs[6] = '{8'hFF,   3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6, 1'b1};
        vecs[7] = '{8'h00,  19, 1'b1, 1'b0, 1'b1, 1'b1, 16'd7, 1'b0};

        src_data         = '0;
        exp_data         = '0;
        rst              = 1'b1;
        enable           = 1'b0;
        clear_err        = 1'b0;
        adc_valid_in     = 1'b1;
        adc_data_in      = '0;
        cnn_ready_in     = 1'b1;
        res_valid_in     = 1'b1;
        res_condition_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("rst_adc_ready",  32'(adc_ready_in),    32'd0);
        check("rst_cnn_valid",  32'(cnn_valid_out),   32'd0);
        check("rst_res_ready",  32'(res_ready_out),   32'd0);
        check("rst_cond_out",   32'(condition_out),   32'd0);
        check("rst_cond_valid", 32'(condition_valid), 32'd0);
        check("rst_busy",       32'(busy),            32'd0);
        check("rst_timeout",    32'(timeout_err),     32'd0);
        check("rst_frame_cnt",  32'(frame_count),     32'd0);

        tick();
        res_valid_in = 1'b0;
        enable       = 1'b1;

        for (int v = 0; v < 8; v++) begin
            stream_frame(vecs[v].pat, 0, got, ok);
            check($sformatf("v%0d_samples", v), 32'(got), 32'(FS));
            check($sformatf("v%0d_order", v),   32'(ok),  32'd1);
            if (vecs[v].delay < 0) begin
                blocked = 1'b1;
                for (int i = 0; i < TO; i++) wait_idle_cycle(blocked);
                check($sformatf("v%0d_wait_block", v), 32'(blocked), 32'd1);
                tick();
                cnn_ready_in = 1'b1;
                @(negedge clk);
                check($sformatf("v%0d_to_busy", v),      32'(busy),          32'd0);
                check($sformatf("v%0d_to_res_ready", v), 32'(res_ready_out), 32'd0);
                check($sformatf("v%0d_to_err", v),       32'(timeout_err),   32'(vecs[v].exp_err));
                check($sformatf("v%0d_to_fc", v),        32'(frame_count),   32'(vecs[v].exp_fc));
            end else begin
                send_result(vecs[v].delay, vecs[v].cond, blocked);
                check($sformatf("v%0d_wait_block", v), 32'(blocked),         32'd1);
                check($sformatf("v%0d_cond_valid", v), 32'(condition_valid), 32'(vecs[v].exp_valid));
                check($sformatf("v%0d_cond_out", v),   32'(condition_out),   32'(vecs[v].exp_cond));
                check($sformatf("v%0d_fc", v),         32'(frame_count),     32'(vecs[v].exp_fc));
                check($sformatf("v%0d_err", v),        32'(timeout_err),     32'(vecs[v].exp_err));
                check($sformatf("v%0d_busy", v),       32'(busy),            32'd1);
            end
            if (vecs[v].clr) begin
                tick();
                clear_err = 1'b1;
                tick();
                clear_err = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_clear_err", v), 32'(timeout_err), 32'd0);
            end
        end

        // enable dropped after the third sample: frame still completes, then IDLE
        stream_frame(8'hFF, 3, got, ok);
        check("drop_samples", 32'(got), 32'(FS));
        check("drop_order",   32'(ok),  32'd1);
        send_result(0, 1'b0, blocked);
        check("drop_wait_block", 32'(blocked),         32'd1);
        check("drop_cond_valid", 32'(condition_valid), 32'd1);
        check("drop_cond_out",   32'(condition_out),   32'd1);
        check("drop_fc",         32'(frame_count),     32'd8);
        check("drop_busy",       32'(busy),            32'd0);
        tick();
        cnn_ready_in = 1'b1;
        adc_valid_in = 1'b1;
        @(negedge clk);
        check("drop_pulse_single", 32'(condition_valid), 32'd0);
        check("drop_adc_ready",    32'(adc_ready_in),    32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("drop_stay_idle", 32'(busy), 32'd0);

        // reset in the middle of a frame aborts immediately
        enable = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        tick();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",     32'(busy),          32'd0);
        check("mid_rst_fc",       32'(frame_count),   32'd0);
        check("mid_rst_cond_out", 32'(condition_out), 32'd0);
        check("mid_rst_adc_rdy",  32'(adc_ready_in),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
